// File: rtl/cache_l1_ctrl.sv
// L1 cache control stage: 4-way tag/valid/dirty arrays, hit/miss FSM, write-back and refill.
// Optional hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_l1_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 4,
  parameter int WAY_W    = 2,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  localparam int NUM_SETS = 1 << INDEX_W,
  localparam int NUM_WAYS = 1 << WAY_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpu_req_valid_i,
  input  logic                cpu_req_rw_i,
  input  logic [ADDR_W-1:0]   cpu_req_addr_i,
  output logic                cpu_req_ready_o,
  output logic                cpu_resp_valid_o,
  output logic                cpu_resp_hit_o,
  output logic                mem_req_valid_o,
  output logic                mem_req_rw_o,
  output logic [ADDR_W-1:0]   mem_req_addr_o,
  input  logic                mem_ack_i,
  output logic [INDEX_W-1:0]  dat_index_o,
  output logic [WAY_W-1:0]    dat_way_o,
  output logic                dat_we_o,
  output logic                dat_fill_o,
  output logic                lru_valid_o,
  output logic [INDEX_W-1:0]  lru_index_o,
  output logic [WAY_W-1:0]    lru_way_o,
  input  logic [WAY_W-1:0]    lru_victim_i,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITE_BACK, S_ALLOCATE} state_t;

  state_t                      state_q;
  logic                        req_rw_q;
  logic [TAG_W-1:0]            req_tag_q;
  logic [INDEX_W-1:0]          req_index_q;
  logic [WAY_W-1:0]            victim_q;
  logic                        refill_q;
  logic [NUM_WAYS-1:0]         valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]         dirty_q [NUM_SETS];
  logic [TAG_W-1:0]            tag_q   [NUM_SETS][NUM_WAYS];

  logic [NUM_WAYS-1:0]         set_valid;
  logic [NUM_WAYS-1:0]         set_dirty;
  logic [NUM_WAYS-1:0]         way_match;
  logic                        hit;
  logic [WAY_W-1:0]            hit_way;
  logic [WAY_W-1:0]            inv_way;
  logic [WAY_W-1:0]            miss_victim;
  logic                        victim_needs_wb;
  logic                        in_compare;
  logic                        in_mem;
  logic                        unused_offset;

  // Offset bits select bytes inside the external data array only.
  assign unused_offset = ^cpu_req_addr_i[OFFSET_W-1:0];

  assign set_valid = valid_q[req_index_q];
  assign set_dirty = dirty_q[req_index_q];

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_cmp
    assign way_match[gi] = set_valid[gi] && (tag_q[req_index_q][gi] == req_tag_q);
  end

  // Descending scans so the lowest-numbered way takes priority.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_match[i]) hit_way = WAY_W'(i);
      if (!set_valid[i]) inv_way = WAY_W'(i);
    end
  end

  assign hit             = |way_match;
  assign miss_victim     = (&set_valid) ? lru_victim_i : inv_way;
  assign victim_needs_wb = set_valid[miss_victim] && set_dirty[miss_victim];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      req_rw_q    <= 1'b0;
      req_tag_q   <= '0;
      req_index_q <= '0;
      victim_q    <= '0;
      refill_q    <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req_valid_i) begin
            req_rw_q    <= cpu_req_rw_i;
            req_tag_q   <= cpu_req_addr_i[ADDR_W-1 -: TAG_W];
            req_index_q <= cpu_req_addr_i[OFFSET_W +: INDEX_W];
            refill_q    <= 1'b0;
            state_q     <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (hit) begin
            if (req_rw_q) dirty_q[req_index_q][hit_way] <= 1'b1;
            refill_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            victim_q <= miss_victim;
            state_q  <= victim_needs_wb ? S_WRITE_BACK : S_ALLOCATE;
          end
        end
        S_WRITE_BACK: begin
          if (mem_ack_i) state_q <= S_ALLOCATE;
        end
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            valid_q[req_index_q][victim_q] <= 1'b1;
            dirty_q[req_index_q][victim_q] <= 1'b0;
            refill_q <= 1'b1;
            state_q  <= S_COMPARE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tags need no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (state_q == S_ALLOCATE && mem_ack_i) begin
      tag_q[req_index_q][victim_q] <= req_tag_q;
    end
  end

  assign in_compare = (state_q == S_COMPARE);
  assign in_mem     = (state_q == S_WRITE_BACK) || (state_q == S_ALLOCATE);

  assign cpu_req_ready_o  = (state_q == S_IDLE);
  assign cpu_resp_valid_o = in_compare && hit;
  assign cpu_resp_hit_o   = in_compare && hit && !refill_q;

  assign mem_req_valid_o = in_mem;
  assign mem_req_rw_o    = (state_q == S_WRITE_BACK);

  always_comb begin
    mem_req_addr_o = '0;
    if (state_q == S_WRITE_BACK) begin
      mem_req_addr_o = {tag_q[req_index_q][victim_q], req_index_q, {OFFSET_W{1'b0}}};
    end else if (state_q == S_ALLOCATE) begin
      mem_req_addr_o = {req_tag_q, req_index_q, {OFFSET_W{1'b0}}};
    end
  end

  assign dat_index_o = (state_q != S_IDLE) ? req_index_q : '0;
  assign lru_index_o = (state_q != S_IDLE) ? req_index_q : '0;
  assign dat_way_o   = (in_compare && hit) ? hit_way : (in_mem ? victim_q : '0);
  assign dat_we_o    = in_compare && hit && req_rw_q;
  assign dat_fill_o  = (state_q == S_ALLOCATE) && mem_ack_i;
  assign lru_valid_o = in_compare && hit;
  assign lru_way_o   = (in_compare && hit) ? hit_way : '0;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (in_compare && hit && !refill_q && hit_cnt_q != 32'hFFFF_FFFF) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (in_compare && !hit && miss_cnt_q != 32'hFFFF_FFFF) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cache_l1_ctrl.sv
// Scoreboard bench for cache_l1_ctrl: directed requests push expected responses,
// memory requests and fills; a monitor pops and compares as the DUT presents them.
module tb_cache_l1_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cpu_req_valid_i = 1'b0;
  logic        cpu_req_rw_i = 1'b0;
  logic [31:0] cpu_req_addr_i = '0;
  logic        cpu_req_ready_o;
  logic        cpu_resp_valid_o;
  logic        cpu_resp_hit_o;
  logic        mem_req_valid_o;
  logic        mem_req_rw_o;
  logic [31:0] mem_req_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [4:0]  dat_index_o;
  logic [1:0]  dat_way_o;
  logic        dat_we_o;
  logic        dat_fill_o;
  logic        lru_valid_o;
  logic [4:0]  lru_index_o;
  logic [1:0]  lru_way_o;
  logic [1:0]  lru_victim_i = '0;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  cache_l1_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_valid_i(cpu_req_valid_i), .cpu_req_rw_i(cpu_req_rw_i),
    .cpu_req_addr_i(cpu_req_addr_i), .cpu_req_ready_o(cpu_req_ready_o),
    .cpu_resp_valid_o(cpu_resp_valid_o), .cpu_resp_hit_o(cpu_resp_hit_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_rw_o(mem_req_rw_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_ack_i(mem_ack_i),
    .dat_index_o(dat_index_o), .dat_way_o(dat_way_o), .dat_we_o(dat_we_o),
    .dat_fill_o(dat_fill_o), .lru_valid_o(lru_valid_o), .lru_index_o(lru_index_o),
    .lru_way_o(lru_way_o), .lru_victim_i(lru_victim_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic hit; logic [1:0] way; logic we; int lat;} resp_t;
  typedef struct {logic rw; logic [31:0] addr;} memreq_t;
  typedef struct {logic [1:0] way; logic [4:0] idx;} fill_t;

  resp_t   resp_q[$];
  memreq_t mem_q[$];
  fill_t   fill_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int ack_dly = 0;
  logic prev_mvalid = 1'b0;
  logic prev_ack = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input logic [22:0] tag, input logic [4:0] idx);
    return {tag, idx, 4'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic exp_resp(input logic hit, input logic [1:0] way, input logic we, input int lat);
    resp_t e;
    e.hit = hit; e.way = way; e.we = we; e.lat = lat;
    resp_q.push_back(e);
  endtask

  task automatic exp_mem(input logic rw, input logic [31:0] addr);
    memreq_t e;
    e.rw = rw; e.addr = addr;
    mem_q.push_back(e);
  endtask

  task automatic exp_fill(input logic [1:0] way, input logic [4:0] idx);
    fill_t e;
    e.way = way; e.idx = idx;
    fill_q.push_back(e);
  endtask

  // Monitor: samples mid-low-phase, after the responder has updated mem_ack_i.
  initial begin
    resp_t   r;
    memreq_t m;
    fill_t   f;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i) begin
        if (cpu_req_valid_i && cpu_req_ready_o) acc_cyc = cyc;
        if (cpu_resp_valid_o) begin
          if (resp_q.size() == 0) begin
            check("resp_unexpected", 32'(cpu_resp_valid_o), 32'd0);
          end else begin
            r = resp_q.pop_front();
            $display("resp: hit=%0b way=%0d we=%0b lat=%0d", cpu_resp_hit_o, dat_way_o, dat_we_o, cyc - acc_cyc);
            check("resp_hit", 32'(cpu_resp_hit_o), 32'(r.hit));
            check("resp_lru_way", 32'(lru_way_o), 32'(r.way));
            check("resp_dat_way", 32'(dat_way_o), 32'(r.way));
            check("resp_dat_we", 32'(dat_we_o), 32'(r.we));
            check("resp_latency", 32'(cyc - acc_cyc), 32'(r.lat));
          end
        end
        if (lru_valid_o != cpu_resp_valid_o) check("lru_strobe_vs_resp", 32'(lru_valid_o), 32'(cpu_resp_valid_o));
        if (mem_req_valid_o && (!prev_mvalid || prev_ack)) begin
          if (mem_q.size() == 0) begin
            check("mem_unexpected", 32'(mem_req_valid_o), 32'd0);
          end else begin
            m = mem_q.pop_front();
            check("mem_rw", 32'(mem_req_rw_o), 32'(m.rw));
            check("mem_addr", mem_req_addr_o, m.addr);
          end
        end
        if (dat_fill_o) begin
          if (fill_q.size() == 0) begin
            check("fill_unexpected", 32'(dat_fill_o), 32'd0);
          end else begin
            f = fill_q.pop_front();
            check("fill_way", 32'(dat_way_o), 32'(f.way));
            check("fill_index", 32'(dat_index_o), 32'(f.idx));
          end
        end
      end
      prev_mvalid = mem_req_valid_o;
      prev_ack    = mem_ack_i;
    end
  end

  // Memory responder: one-cycle ack, ack_dly cycles after a request is seen.
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      if (mem_req_valid_o && !rst_i) begin
        if (ack_dly > 0) begin
          repeat (ack_dly) @(negedge clk_i);
          #1;
        end
        mem_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
      end
    end
  end

  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [1:0] vict);
    int n;
    @(posedge clk_i);
    #1;
    lru_victim_i    = vict;
    cpu_req_valid_i = 1'b1;
    cpu_req_rw_i    = rw;
    cpu_req_addr_i  = addr;
    @(posedge clk_i);
    #1;
    cpu_req_valid_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      #3;
      n++;
    end while (!cpu_resp_valid_o && n < 60);
    if (!cpu_resp_valid_o) check("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", 32'(cpu_req_ready_o), 32'd1);
    check("rst_resp_valid", 32'(cpu_resp_valid_o), 32'd0);
    check("rst_mem_valid", 32'(mem_req_valid_o), 32'd0);
    check("rst_lru_valid", 32'(lru_valid_o), 32'd0);
    check("rst_fill", 32'(dat_fill_o), 32'd0);
    rst_i = 1'b0;

    // Clean miss into empty set 4, ack in the same cycle as the request
    ack_dly = 0;
    exp_mem(1'b0, 32'h0000_1040); exp_fill(2'd0, 5'd4); exp_resp(1'b0, 2'd0, 1'b0, 3);
    do_req(1'b0, 32'h0000_1040, 2'd0);
    exp_resp(1'b1, 2'd0, 1'b0, 1);
    do_req(1'b0, 32'h0000_1040, 2'd0);
    exp_resp(1'b1, 2'd0, 1'b1, 1);
    do_req(1'b1, 32'h0000_1040, 2'd3);
    for (int t = 9; t <= 11; t++) begin
      exp_mem(1'b0, mk(23'(t), 5'd4)); exp_fill(2'(t - 8), 5'd4); exp_resp(1'b0, 2'(t - 8), 1'b0, 3);
      do_req(1'b0, mk(23'(t), 5'd4), 2'd0);
    end

    // Full set, LRU picks dirty way 0: write-back then refill
    ack_dly = 2;
    exp_mem(1'b1, 32'h0000_1040); exp_mem(1'b0, 32'h0000_1840); exp_fill(2'd0, 5'd4);
    exp_resp(1'b0, 2'd0, 1'b0, 8);
    do_req(1'b0, 32'h0000_1840, 2'd0);
    exp_resp(1'b1, 2'd1, 1'b0, 1);
    do_req(1'b0, mk(23'd9, 5'd4), 2'd2);

    // Set 5: four clean fills, then LRU victims with and without dirty data
    for (int t = 1; t <= 4; t++) begin
      exp_mem(1'b0, mk(23'(t), 5'd5)); exp_fill(2'(t - 1), 5'd5); exp_resp(1'b0, 2'(t - 1), 1'b0, 5);
      do_req(1'b0, mk(23'(t), 5'd5), 2'd0);
    end
    exp_mem(1'b0, mk(23'd5, 5'd5)); exp_fill(2'd2, 5'd5); exp_resp(1'b0, 2'd2, 1'b0, 5);
    do_req(1'b0, mk(23'd5, 5'd5), 2'd2);
    exp_mem(1'b0, mk(23'd6, 5'd5)); exp_fill(2'd2, 5'd5); exp_resp(1'b0, 2'd2, 1'b0, 5);
    do_req(1'b0, mk(23'd6, 5'd5), 2'd2);
    exp_mem(1'b0, mk(23'd7, 5'd5)); exp_fill(2'd1, 5'd5); exp_resp(1'b0, 2'd1, 1'b1, 5);
    do_req(1'b1, mk(23'd7, 5'd5), 2'd1);
    exp_mem(1'b1, mk(23'd7, 5'd5)); exp_mem(1'b0, mk(23'd8, 5'd5)); exp_fill(2'd1, 5'd5);
    exp_resp(1'b0, 2'd1, 1'b0, 8);
    do_req(1'b0, mk(23'd8, 5'd5), 2'd1);

    // Reset in the middle of a refill
    ack_dly = 20;
    exp_mem(1'b0, mk(23'd13, 5'd6));
    @(posedge clk_i);
    #1;
    cpu_req_valid_i = 1'b1; cpu_req_rw_i = 1'b0; cpu_req_addr_i = mk(23'd13, 5'd6);
    @(posedge clk_i);
    #1;
    cpu_req_valid_i = 1'b0;
    n = 0;
    while (!mem_req_valid_o && n < 20) begin
      @(negedge clk_i);
      #3;
      n++;
    end
    check("abort_memreq_seen", 32'(mem_req_valid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("abort_memreq_low", 32'(mem_req_valid_o), 32'd0);
    check("abort_ready", 32'(cpu_req_ready_o), 32'd1);
    check("abort_resp_valid", 32'(cpu_resp_valid_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (30) @(posedge clk_i);
    ack_dly = 0;

    // After reset: 2 misses, 3 hits
    exp_mem(1'b0, mk(23'd13, 5'd6)); exp_fill(2'd0, 5'd6); exp_resp(1'b0, 2'd0, 1'b0, 3);
    do_req(1'b0, mk(23'd13, 5'd6), 2'd0);
    exp_resp(1'b1, 2'd0, 1'b0, 1);
    do_req(1'b0, mk(23'd13, 5'd6), 2'd0);
    exp_resp(1'b1, 2'd0, 1'b1, 1);
    do_req(1'b1, mk(23'd13, 5'd6), 2'd0);
    exp_mem(1'b0, 32'h0000_1040); exp_fill(2'd0, 5'd4); exp_resp(1'b0, 2'd0, 1'b0, 3);
    do_req(1'b0, 32'h0000_1040, 2'd0);
    exp_resp(1'b1, 2'd0, 1'b0, 1);
    do_req(1'b0, 32'h0000_1040, 2'd0);

    repeat (5) @(posedge clk_i);
    #1;
`ifdef CACHE_STATS_EN
    check("hit_cnt", hit_cnt_o, 32'd3);
    check("miss_cnt", miss_cnt_o, 32'd2);
`else
    check("hit_cnt", hit_cnt_o, 32'd0);
    check("miss_cnt", miss_cnt_o, 32'd0);
`endif
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    check("fill_q_drained", 32'(fill_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
